// File: rtl/gpio_mailbox_bridge_pkg.sv
// Shared definitions for the GPIO mailbox bridge: flag bit positions and TX FSM encoding.
package gpio_mailbox_bridge_pkg;

  // Bit positions inside the 8-bit flag bytes exchanged with the core
  localparam int READ_FLICKER  = 0;
  localparam int WRITE_FLICKER = 1;

  // TX side: present a byte, toggle the write flicker, then wait for the core's read flicker
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_ACK = 2'd2
  } tx_state_t;

endpackage

// File: rtl/mailbox_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module mailbox_sync_fifo #(
  parameter int pDEPTH = 16,
  parameter int pWIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       push,
  input  logic [pWIDTH-1:0]          push_data,
  input  logic                       pop,
  output logic [pWIDTH-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(pDEPTH):0]    level
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW:0] DEPTH_COUNT = (AW+1)'(pDEPTH);

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign full     = (count == DEPTH_COUNT);
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gpio_mailbox_bridge.sv
// Byte-stream bridge between the USB register block and the PULPino GPIO toggle mailbox.
// Handshake (both stream ports): a byte moves on a clock edge where valid and ready are both 1;
// valid never waits on ready. Mailbox side: every byte is announced by toggling a write flicker
// and acknowledged by toggling the partner's read flicker.
module gpio_mailbox_bridge
  import gpio_mailbox_bridge_pkg::*;
#(
  parameter int pFIFO_DEPTH  = 16,
  parameter int pACK_TIMEOUT = 65535
) (
  input  logic                            crypto_clk,
  input  logic                            reset_i,
  input  logic [7:0]                      s_tx_data,
  input  logic                            s_tx_valid,
  output logic                            s_tx_ready,
  output logic [7:0]                      m_rx_data,
  output logic                            m_rx_valid,
  input  logic                            m_rx_ready,
  input  logic [7:0]                      I_pulpino_data,
  input  logic [7:0]                      I_pulpino_flags,
  output logic [7:0]                      O_ext_data,
  output logic [7:0]                      O_ext_flags,
  output logic [$clog2(pFIFO_DEPTH):0]    O_tx_level,
  output logic [$clog2(pFIFO_DEPTH):0]    O_rx_level,
  output logic                            O_timeout_err,
  output logic                            O_proto_err,
  input  logic                            I_clear_err,
  output tx_state_t                       tx_state_dbg
);

  localparam int TW = (pACK_TIMEOUT > 1) ? $clog2(pACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(pACK_TIMEOUT - 1);

  tx_state_t     state_q, state_d;
  logic [TW-1:0] timer;
  logic [1:0]    flag_q;
  logic          ack_tog, new_tog;
  logic          write_flick, read_flick;
  logic          tx_full, tx_empty, tx_pop;
  logic [7:0]    tx_head;
  logic          load_data, toggle_w, clr_timer, inc_timer, set_timeout;
  logic          rx_full, rx_empty, rx_pop, rx_space;
  logic          rx_push, toggle_r, set_pend, clr_pend, set_proto;
  logic [7:0]    rx_push_data;
  logic          rx_pending;
  logic [7:0]    pend_data;
  logic          unused_flags;

  // Only the two flicker bits carry meaning; the rest of the core's flag byte is ignored
  assign unused_flags = ^I_pulpino_flags[7:2];

  assign ack_tog    = I_pulpino_flags[READ_FLICKER]  ^ flag_q[READ_FLICKER];
  assign new_tog    = I_pulpino_flags[WRITE_FLICKER] ^ flag_q[WRITE_FLICKER];
  assign s_tx_ready = ~tx_full & ~reset_i;
  assign m_rx_valid = ~rx_empty;
  assign rx_pop     = m_rx_valid & m_rx_ready;
  assign rx_space   = ~rx_full | rx_pop;
  assign tx_state_dbg = state_q;

  // Flag history; also loads during reset so the first cycle after release sees no stale toggle
  always_ff @(posedge crypto_clk) begin
    flag_q <= I_pulpino_flags[1:0];
  end

  mailbox_sync_fifo #(.pDEPTH(pFIFO_DEPTH), .pWIDTH(8)) u_tx_fifo (
    .clk       (crypto_clk),
    .reset_i   (reset_i),
    .push      (s_tx_valid & s_tx_ready),
    .push_data (s_tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (O_tx_level)
  );

  mailbox_sync_fifo #(.pDEPTH(pFIFO_DEPTH), .pWIDTH(8)) u_rx_fifo (
    .clk       (crypto_clk),
    .reset_i   (reset_i),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .pop_data  (m_rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (O_rx_level)
  );

  // TX FSM state register
  always_ff @(posedge crypto_clk) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // TX FSM next state and datapath controls
  always_comb begin
    state_d     = state_q;
    tx_pop      = 1'b0;
    load_data   = 1'b0;
    toggle_w    = 1'b0;
    clr_timer   = 1'b0;
    inc_timer   = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop    = 1'b1;
          load_data = 1'b1;
          state_d   = PRESENT;
        end
      end
      PRESENT: begin
        toggle_w  = 1'b1;
        clr_timer = 1'b1;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_tog) begin
          state_d = IDLE;
        end else if (timer == TIMER_LAST) begin
          set_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          inc_timer = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TX datapath: presented byte, write flicker, ack timer and sticky timeout flag
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      O_ext_data    <= '0;
      write_flick   <= 1'b0;
      timer         <= '0;
      O_timeout_err <= 1'b0;
    end else begin
      if (load_data) O_ext_data <= tx_head;
      if (toggle_w)  write_flick <= ~write_flick;
      if (clr_timer)      timer <= '0;
      else if (inc_timer) timer <= timer + 1'b1;
      if (set_timeout)      O_timeout_err <= 1'b1;
      else if (I_clear_err) O_timeout_err <= 1'b0;
    end
  end

  // RX decisions: push live or pending byte when there is room, otherwise withhold the ack
  always_comb begin
    rx_push      = 1'b0;
    rx_push_data = I_pulpino_data;
    toggle_r     = 1'b0;
    set_pend     = 1'b0;
    clr_pend     = 1'b0;
    set_proto    = 1'b0;
    if (rx_pending) begin
      if (rx_space) begin
        rx_push      = 1'b1;
        rx_push_data = pend_data;
        toggle_r     = 1'b1;
        clr_pend     = 1'b1;
      end
      if (new_tog) set_proto = 1'b1;
    end else if (new_tog) begin
      if (rx_space) begin
        rx_push  = 1'b1;
        toggle_r = 1'b1;
      end else begin
        set_pend = 1'b1;
      end
    end
  end

  // RX state: read flicker, pending byte holder and sticky protocol error
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      read_flick  <= 1'b0;
      rx_pending  <= 1'b0;
      pend_data   <= '0;
      O_proto_err <= 1'b0;
    end else begin
      if (toggle_r) read_flick <= ~read_flick;
      if (set_pend) begin
        rx_pending <= 1'b1;
        pend_data  <= I_pulpino_data;
      end else if (clr_pend) begin
        rx_pending <= 1'b0;
      end
      if (set_proto)        O_proto_err <= 1'b1;
      else if (I_clear_err) O_proto_err <= 1'b0;
    end
  end

  // Flag byte towards the core; unused upper bits stay low
  always_comb begin
    O_ext_flags                = '0;
    O_ext_flags[READ_FLICKER]  = read_flick;
    O_ext_flags[WRITE_FLICKER] = write_flick;
  end

endmodule
